// File: rtl/keyboard_scan_pkg.sv
// kbd_pkg: shared matrix geometry constants and key index helper for keyboard_scan
package kbd_pkg;
    localparam int KBD_ROWS = 4;
    localparam int KBD_COLS = 4;
    localparam int KBD_KEYS = KBD_ROWS * KBD_COLS;

    function automatic int key_idx(input int r, input int c);
        return KBD_COLS * r + c;
    endfunction
endpackage

// File: rtl/keyboard_scan_if.sv
// keyboard_scan_if: matrix pads plus debounced key level/pulse outputs
interface keyboard_scan_if;
    import kbd_pkg::*;
    logic [KBD_COLS-1:0] col;
    logic [KBD_ROWS-1:0] row;
    logic [KBD_KEYS-1:0] key_state;
    logic [KBD_KEYS-1:0] key_pulse;
    modport master (output col, key_state, key_pulse, input row);
    modport slave (input col, key_state, key_pulse, output row);
endinterface

// File: rtl/keyboard_scan_cell.sv
// key_debounce_cell: per-key debounce counter, debounced level and press pulse
module key_debounce_cell #(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic sample_en,
    input  logic sample,
    output logic state,
    output logic pulse
);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    logic [CW-1:0] cnt;
    logic flip;
    assign flip = sample_en && (sample != state) && (cnt == CW'(DEBOUNCE_SCANS - 1));
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt   <= '0;
            state <= 1'b0;
            pulse <= 1'b0;
        end else begin
            pulse <= flip && !state;
            if (flip) state <= ~state;
            if (sample_en) cnt <= (sample == state || flip) ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/keyboard_scan.sv
// keyboard_scan: 4x4 active-low matrix scanner with row sync, column rotation and per-key debounce
module keyboard_scan
    import kbd_pkg::*;
#(
    parameter int SCAN_CYCLES    = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic clk,
    input  logic rstn,
    keyboard_scan_if.master bus
);
    localparam int DW = $clog2(SCAN_CYCLES);
    logic [DW-1:0] dwell;
    logic [1:0] col_idx;
    logic [KBD_ROWS-1:0] row_m, row_s;
    logic sample_pt;
    logic [KBD_KEYS-1:0] state, pulse;
    assign sample_pt = dwell == DW'(SCAN_CYCLES - 1);
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row_m   <= '1;
            row_s   <= '1;
            dwell   <= '0;
            col_idx <= '0;
            bus.col <= 4'b1110;
        end else begin
            row_m <= bus.row;
            row_s <= row_m;
            dwell <= sample_pt ? '0 : dwell + 1'b1;
            if (sample_pt) begin
                col_idx <= col_idx + 2'd1;
                bus.col <= ~(4'b0001 << (col_idx + 2'd1));
            end
        end
    end
    // each cell only advances at its own column's sample point
    for (genvar r = 0; r < KBD_ROWS; r++) begin : g_row
        for (genvar c = 0; c < KBD_COLS; c++) begin : g_col
            key_debounce_cell #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_cell (
                .clk       (clk),
                .rstn      (rstn),
                .sample_en (sample_pt && col_idx == 2'(c)),
                .sample    (~row_s[r]),
                .state     (state[key_idx(r, c)]),
                .pulse     (pulse[key_idx(r, c)])
            );
        end
    end
    assign bus.key_state = state;
    assign bus.key_pulse = pulse;
endmodule

// File: tb/tb_keyboard_scan.sv
// tb_keyboard_scan: directed checks of rotation, press/release, bounce, same-column and reset behaviour
module tb_keyboard_scan;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic [15:0] held = '0;
    int e = 0;
    int pass = 0;
    int total = 0;
    logic [3:0] cols [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    keyboard_scan_if bus ();

    keyboard_scan #(.SCAN_CYCLES(4), .DEBOUNCE_SCANS(2)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        bus.row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (held[4*r+c] && !bus.col[c]) bus.row[r] = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) pass++;
        else $display("FAIL %s at e=%0d: got %h expected %h", tag, e, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        e++;
    endtask

    task automatic do_reset(input logic [15:0] keys);
        rstn = 1'b0;
        held = keys;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        e = 0;
    endtask

    initial begin
        @(negedge clk);
        chk("rst_col", 32'(bus.col), 32'h0000000e);
        chk("rst_state", 32'(bus.key_state), 0);
        chk("rst_pulse", 32'(bus.key_pulse), 0);

        do_reset('0);
        for (int i = 0; i < 32; i++) begin
            chk("rot_col", 32'(bus.col), 32'(cols[(e / 4) % 4]));
            chk("rot_state", 32'(bus.key_state), 0);
            chk("rot_pulse", 32'(bus.key_pulse), 0);
            tick();
        end

        do_reset(16'h0020);
        while (e < 24) begin
            chk("press_pre", 32'({bus.key_state, bus.key_pulse}), 0);
            tick();
        end
        chk("press_state", 32'(bus.key_state), 32'h0020);
        chk("press_pulse", 32'(bus.key_pulse), 32'h0020);
        while (e < 57) begin
            tick();
            chk("hold_state", 32'(bus.key_state), 32'h0020);
            chk("hold_pulse", 32'(bus.key_pulse), 0);
        end
        held = '0;
        while (e < 100) begin
            tick();
            chk("rel_state", 32'(bus.key_state), (e >= 88) ? 32'h0 : 32'h0020);
            chk("rel_pulse", 32'(bus.key_pulse), 0);
        end

        do_reset('0);
        while (e < 64) begin
            if (e == 8) held = 16'h0400;
            if (e == 12) held = '0;
            chk("bounce_state", 32'(bus.key_state), 0);
            chk("bounce_pulse", 32'(bus.key_pulse), 0);
            tick();
        end

        do_reset(16'h8008);
        while (e < 32) begin
            chk("pair_pre", 32'(bus.key_pulse), 0);
            tick();
        end
        chk("pair_pulse", 32'(bus.key_pulse), 32'h8008);
        chk("pair_state", 32'(bus.key_state), 32'h8008);
        tick();
        chk("pair_pulse_end", 32'(bus.key_pulse), 0);
        chk("pair_hold", 32'(bus.key_state), 32'h8008);

        do_reset(16'h0001);
        while (e < 5) tick();
        rstn = 1'b0;
        #1;
        chk("async_col", 32'(bus.col), 32'h0000000e);
        chk("async_state", 32'(bus.key_state), 0);
        chk("async_pulse", 32'(bus.key_pulse), 0);
        do_reset(16'h0001);
        while (e < 20) begin
            chk("rearm_pre", 32'(bus.key_pulse), 0);
            tick();
        end
        chk("rearm_pulse", 32'(bus.key_pulse), 32'h0001);
        chk("rearm_state", 32'(bus.key_state), 32'h0001);
        tick();
        chk("rearm_pulse_end", 32'(bus.key_pulse), 0);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
